// File: rtl/audio_adc_deserializer_if.sv
// Codec-side ADC serial pins plus the parallel sample bus handed to the filter stages.
// sample_valid is a one-cycle strobe with no ready: both channel buses are stable from it until the next strobe.
interface audio_adc_deserializer_if;
    logic        AUD_ADCLRCK;
    logic        AUD_ADCDAT;
    logic [31:0] left_channel_audio_out;
    logic [31:0] right_channel_audio_out;
    logic        sample_valid;
    logic        frame_error;
    logic [1:0]  state;

    modport master (
        output AUD_ADCLRCK, AUD_ADCDAT,
        input  left_channel_audio_out, right_channel_audio_out, sample_valid, frame_error, state
    );

    modport slave (
        input  AUD_ADCLRCK, AUD_ADCDAT,
        output left_channel_audio_out, right_channel_audio_out, sample_valid, frame_error, state
    );
endinterface

// File: rtl/audio_adc_deserializer.sv
// I2S / left-justified ADC deserializer: shifts AUD_ADCDAT MSB-first on AUD_BCLK and
// presents sign-extended 32-bit left/right samples together once per LRCK frame.
module audio_adc_deserializer #(
    parameter int DATA_WIDTH = 24,
    parameter int I2S_DELAY  = 1
) (
    input logic AUD_BCLK,
    input logic reset,
    audio_adc_deserializer_if.slave bus
);
    typedef enum logic [1:0] {SYNC = 2'd0, DELAY = 2'd1, SHIFT = 2'd2, HOLD = 2'd3} state_t;

    state_t                state;
    logic                  lrck_q;
    logic [DATA_WIDTH-1:0] shreg;
    logic [5:0]            bitcnt;
    logic [5:0]            dcnt;
    logic [31:0]           left_hold;
    logic [31:0]           left_out;
    logic [31:0]           right_out;
    logic                  valid_q;
    logic                  error_q;

    logic                  edge_det;
    logic                  slot_start;
    logic                  shift_now;
    logic                  full;
    logic                  short_slot;
    logic                  commit;
    logic [5:0]            nbits;
    logic [DATA_WIDTH-1:0] sh_next;
    logic [DATA_WIDTH-1:0] word;

    function automatic logic [31:0] sext(input logic [DATA_WIDTH-1:0] w);
        logic [31:0] r;
        r = {32{w[DATA_WIDTH-1]}};
        r[DATA_WIDTH-1:0] = w;
        return r;
    endfunction

    always_comb begin
        edge_det   = bus.AUD_ADCLRCK != lrck_q;
        slot_start = edge_det && !(state == SYNC && bus.AUD_ADCLRCK);
        // With a delay, the bit sampled on the edge cycle is still the old slot's last bit.
        shift_now  = (state == SHIFT) && !(edge_det && I2S_DELAY == 0);
        sh_next    = shift_now ? ((shreg << 1) | DATA_WIDTH'(bus.AUD_ADCDAT)) : shreg;
        nbits      = bitcnt + 6'(shift_now);
        full       = shift_now && (nbits == 6'(DATA_WIDTH));
        short_slot = edge_det && !full && (state == DELAY || state == SHIFT);
        commit     = full || short_slot;
        word       = full ? sh_next : (sh_next << (DATA_WIDTH - int'(nbits)));
    end

    always_ff @(posedge AUD_BCLK or negedge reset) begin
        if (!reset) begin
            state     <= SYNC;
            lrck_q    <= 1'b0;
            shreg     <= '0;
            bitcnt    <= '0;
            dcnt      <= '0;
            left_hold <= '0;
            left_out  <= '0;
            right_out <= '0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            lrck_q  <= bus.AUD_ADCLRCK;
            valid_q <= 1'b0;
            // lrck_q is the level of the slot that is ending, also on an edge cycle.
            if (commit) begin
                if (!lrck_q) begin
                    left_hold <= sext(word);
                end else begin
                    left_out  <= left_hold;
                    right_out <= sext(word);
                    valid_q   <= 1'b1;
                end
            end
            if (short_slot) error_q <= 1'b1;

            if (slot_start) begin
                dcnt <= 6'd1;
                if (I2S_DELAY == 0) begin
                    shreg  <= DATA_WIDTH'(bus.AUD_ADCDAT);
                    bitcnt <= 6'd1;
                    state  <= SHIFT;
                end else begin
                    shreg  <= '0;
                    bitcnt <= '0;
                    state  <= (I2S_DELAY == 1) ? SHIFT : DELAY;
                end
            end else begin
                case (state)
                    DELAY: begin
                        if (dcnt == 6'(I2S_DELAY - 1)) state <= SHIFT;
                        else dcnt <= dcnt + 6'd1;
                    end
                    SHIFT: begin
                        shreg  <= sh_next;
                        bitcnt <= nbits;
                        if (full) state <= HOLD;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.left_channel_audio_out  = left_out;
    assign bus.right_channel_audio_out = right_out;
    assign bus.sample_valid            = valid_q;
    assign bus.frame_error             = error_q;
    assign bus.state                   = state;
endmodule
